// File: rtl/iiitb_sd_ser_if.sv
// Parallel-in / serial-out handshake bundle for iiitb_sd_ser.
// master: upstream word source (drives data_in/data_valid).
// slave : the serializer (drives data_ready and the serial-side outputs).
interface iiitb_sd_ser_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             sequence_out;
  logic             bit_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output data_in, data_valid,
    input  data_ready, sequence_out, bit_valid, frame_start, busy
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, sequence_out, bit_valid, frame_start, busy
  );
endinterface

// File: rtl/iiitb_sd_ser.sv
// iiitb_sd_ser: WIDTH-bit parallel word to LSB-first serial stream feeding
// a downstream sequence detector. One bit per clock, bit 0 appears the cycle
// after the accept edge, back-to-back frames when a word is accepted on the
// final bit cycle.
// Optional feature: define IIITB_SD_SER_PARITY_EN to append an even-parity
// bit (XOR of the data bits) after the last data bit of every frame.
module iiitb_sd_ser #(
  parameter int WIDTH = 8
) (
  input logic          clock,
  input logic          reset,
  iiitb_sd_ser_if.slave bus
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifndef IIITB_SD_SER_PARITY_EN
  // Without parity, the last data bit is the handoff cycle, so ready is
  // raised when the counter steps onto it.
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
`endif

  typedef enum logic [1:0] {
    SHIFT  = 2'd0,
    IDLE   = 2'd1
`ifdef IIITB_SD_SER_PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
`ifdef IIITB_SD_SER_PARITY_EN
  logic             par;
`endif
  logic             ready;
  logic             seq;
  logic             bv;
  logic             fs;
  logic             busy_r;
  logic             accept;

  // Ready is a registered output, so accept never looks at the combinational
  // state of data_valid beyond the current edge.
  assign accept = bus.data_valid & ready;

  assign bus.data_ready   = ready;
  assign bus.sequence_out = seq;
  assign bus.bit_valid    = bv;
  assign bus.frame_start  = fs;
  assign bus.busy         = busy_r;

  // Frame FSM: all outputs registered; shreg holds the not-yet-emitted bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      shreg  <= '0;
`ifdef IIITB_SD_SER_PARITY_EN
      par    <= 1'b0;
`endif
      ready  <= 1'b0;
      seq    <= 1'b0;
      bv     <= 1'b0;
      fs     <= 1'b0;
      busy_r <= 1'b0;
    end else if (accept) begin
      // Bit 0 goes out directly; the remaining bits wait in shreg.
      state  <= SHIFT;
      cnt    <= '0;
      shreg  <= {1'b0, bus.data_in[WIDTH-1:1]};
`ifdef IIITB_SD_SER_PARITY_EN
      par    <= ^bus.data_in;
`endif
      ready  <= 1'b0;
      seq    <= bus.data_in[0];
      bv     <= 1'b1;
      fs     <= 1'b1;
      busy_r <= 1'b1;
    end else begin
      case (state)
        SHIFT: begin
          if (cnt == LAST) begin
            cnt <= '0;
            fs  <= 1'b0;
`ifdef IIITB_SD_SER_PARITY_EN
            state  <= PARITY;
            seq    <= par;
            bv     <= 1'b1;
            busy_r <= 1'b1;
            ready  <= 1'b1;
`else
            state  <= IDLE;
            seq    <= 1'b0;
            bv     <= 1'b0;
            busy_r <= 1'b0;
            ready  <= 1'b1;
`endif
          end else begin
            cnt   <= cnt + 1'b1;
            seq   <= shreg[0];
            shreg <= shreg >> 1;
            fs    <= 1'b0;
`ifdef IIITB_SD_SER_PARITY_EN
            ready <= 1'b0;
`else
            ready <= (cnt == PENULT);
`endif
          end
        end
`ifdef IIITB_SD_SER_PARITY_EN
        PARITY: begin
          state  <= IDLE;
          seq    <= 1'b0;
          bv     <= 1'b0;
          fs     <= 1'b0;
          busy_r <= 1'b0;
          ready  <= 1'b1;
        end
`endif
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          seq    <= 1'b0;
          bv     <= 1'b0;
          fs     <= 1'b0;
          busy_r <= 1'b0;
          ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iiitb_sd_ser.sv
// Scoreboard bench for iiitb_sd_ser (WIDTH=8). Expected bits are queued when
// a word is offered at a ready cycle; a negedge monitor pops one entry per
// bit_valid cycle and compares it with the serial outputs.
module tb_iiitb_sd_ser;

  localparam int WIDTH = 8;

  logic clock;
  logic reset;

  iiitb_sd_ser_if #(.WIDTH(WIDTH)) bus ();

  iiitb_sd_ser #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit seq;
    bit fs;
    bit contig;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miss    = 0;
  bit   prev_bv = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miss++;
      $display("FAIL %s: act=%0h req=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Hand-derived frame content: LSB first, frame_start on bit 0, then the
  // even-parity bit when the feature is built in.
  task automatic push_word(input logic [7:0] w, input bit contig);
    for (int i = 0; i < WIDTH; i++) begin
      exp_t e;
      e.seq    = w[i];
      e.fs     = (i == 0);
      e.contig = (i == 0) ? contig : 1'b1;
      q.push_back(e);
    end
`ifdef IIITB_SD_SER_PARITY_EN
    begin
      exp_t p;
      p.seq    = ^w;
      p.fs     = 1'b0;
      p.contig = 1'b1;
      q.push_back(p);
    end
`endif
  endtask

  // Offer w, wait (bounded) for a ready cycle, queue its bits, cross the accept edge.
  task automatic send(input logic [7:0] w, input bit contig);
    int n = 0;
    @(negedge clock);
    bus.data_in    = w;
    bus.data_valid = 1'b1;
    while (!bus.data_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!bus.data_ready) begin
      vectors++;
      miss++;
      $display("FAIL accept_timeout: act=ready_low req=ready_high word=%0h", w);
    end else begin
      push_word(w, contig);
    end
    @(posedge clock);
  endtask

  task automatic idle();
    @(negedge clock);
    bus.data_valid = 1'b0;
  endtask

  // Monitor: every emitted bit must match the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset && bus.bit_valid) begin
      if (q.size() == 0) begin
        vectors++;
        miss++;
        $display("FAIL unexpected_bit: act=bit_valid=1 seq=%0b req=no_bit at %0t",
                 bus.sequence_out, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sequence_out", {31'd0, bus.sequence_out}, {31'd0, e.seq});
        chk("frame_start",  {31'd0, bus.frame_start},  {31'd0, e.fs});
        chk("busy_in_frame", {31'd0, bus.busy}, 32'd1);
        if (e.contig)
          chk("contiguous", {31'd0, prev_bv}, 32'd1);
      end
    end
    prev_bv = bus.bit_valid;
  end

  initial begin
    reset          = 1'b1;
    bus.data_in    = '0;
    bus.data_valid = 1'b0;

    // Reset held two cycles: every output low, including data_ready.
    repeat (2) begin
      @(negedge clock);
      chk("reset_outputs",
          {27'd0, bus.data_ready, bus.sequence_out, bus.bit_valid, bus.frame_start, bus.busy},
          32'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset_ready", {31'd0, bus.data_ready}, 32'd1);
    chk("post_reset_others",
        {28'd0, bus.sequence_out, bus.bit_valid, bus.frame_start, bus.busy}, 32'd0);

    // Single frames: 0D -> 1,0,1,1,0,0,0,0 (parity 1); B2 -> parity 0.
    send(8'h0D, 1'b0);
    idle();
    repeat (10) @(negedge clock);
    chk("idle_seq_low", {30'd0, bus.sequence_out, bus.bit_valid}, 32'd0);
    send(8'hB2, 1'b0);
    idle();
    repeat (10) @(negedge clock);

    // data_valid held high: 0D then F0 with no gap between frames.
    send(8'h0D, 1'b0);
    send(8'hF0, 1'b1);
    idle();
    repeat (10) @(negedge clock);

    // data_in churning mid-frame must not disturb the latched word.
    send(8'hA5, 1'b0);
    repeat (6) begin
      @(negedge clock);
      bus.data_in = 8'($urandom);
    end
    send(8'h3C, 1'b1);
    idle();
    repeat (10) @(negedge clock);

    // Reset during bit 4 of FF: outputs drop at once, nothing resumes.
    send(8'hFF, 1'b0);
    idle();
    repeat (4) @(negedge clock);
    #1 reset = 1'b1;
    q.delete();
    #1;
    chk("async_reset_drop",
        {27'd0, bus.data_ready, bus.sequence_out, bus.bit_valid, bus.frame_start, bus.busy},
        32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("after_abort_idle", {29'd0, bus.bit_valid, bus.busy, bus.data_ready}, 32'd1);
    end

    repeat (4) @(negedge clock);
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule

// File: doc/iiitb_sd_ser.md
IIITB_SD_SER -- requirements
Module: iiitb_sd_ser

Interface
REQ-001 Parameter WIDTH, default 8: number of data bits per frame, legal range 2..16.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-004 data_in  input  WIDTH  parallel word to serialize; sampled only on an accept edge.
REQ-005 data_valid  input  1  upstream offers data_in this cycle.
REQ-006 data_ready  output  1  block can accept a word this cycle.
REQ-007 sequence_out  output  1  serial bit stream driving the downstream sequence detector input.
REQ-008 bit_valid  output  1  sequence_out carries a frame bit this cycle.
REQ-009 frame_start  output  1  one-cycle pulse coinciding with the first bit of each frame.
REQ-010 busy  output  1  a frame is in progress (SHIFT or PARITY state).

Function
REQ-011 FSM states SHIFT, IDLE, PARITY; PARITY exists only when the configuration feature is compiled in.
REQ-012 Accept occurs on a rising edge where data_valid=1 and data_ready=1; data_in is latched into a WIDTH-bit shift register.
REQ-013 data_ready SHALL be 1 in IDLE and on the final bit cycle of a frame, 0 otherwise; it never depends on data_valid.
REQ-014 Latency: bit 0 of an accepted word appears on sequence_out in the cycle immediately after the accept edge.
REQ-015 Bit order LSB first, one bit per clock, no gaps within a frame.
REQ-016 A bit counter (ceil(log2(WIDTH)) bits) counts 0..WIDTH-1 and wraps to 0 at frame end; it never exceeds WIDTH-1.
REQ-017 IDLE -> SHIFT on accept; SHIFT stays until counter = WIDTH-1; then -> PARITY (feature in) or -> IDLE/SHIFT (feature out).
REQ-018 Accept on the final bit cycle starts the next frame back-to-back: next cycle carries bit 0 of the new word with frame_start=1.
REQ-019 With no accept on the final bit cycle the FSM returns to IDLE; sequence_out=0, bit_valid=0 in IDLE.
REQ-020 frame_start=1 exactly on bit-0 cycles; bit_valid=1 on every data and parity bit cycle.
REQ-021 data_in and data_valid are ignored while data_ready=0; a changing data_in mid-frame does not alter the frame.

Reset
REQ-022 While reset=1: state IDLE, counter 0, shift register 0, sequence_out=0, bit_valid=0, frame_start=0, busy=0, data_ready=0.
REQ-023 First cycle after reset deasserts: data_ready=1, all other outputs 0.
REQ-024 Reset asserted mid-frame abandons the frame; no remaining bits are emitted after deassertion.

Configuration
REQ-025 Macro IIITB_SD_SER_PARITY_EN: when defined, an even-parity bit (XOR of the WIDTH data bits) follows the last data bit in state PARITY, with bit_valid=1; data_ready=1 during PARITY instead of the last data cycle.
REQ-026 Without IIITB_SD_SER_PARITY_EN: frames are exactly WIDTH cycles, no PARITY state or parity logic.

Verification
REQ-027 Reset for 2 cycles, release -> all outputs 0 during reset, data_ready=1 one cycle later.
REQ-028 WIDTH=8, accept 8'h0D -> sequence_out 1,0,1,1,0,0,0,0 on 8 consecutive cycles, frame_start only on first, bit_valid=1 throughout.
REQ-029 PARITY_EN defined, accept 8'h0D -> 9 bits, ninth bit 1; accept 8'hB2 -> ninth bit 0.
REQ-030 data_valid held high with words 8'h0D then 8'hF0 -> 16 contiguous bits, frame_start at cycles 1 and 9, busy never drops.
REQ-031 Reset asserted during bit 4 of 8'hFF -> sequence_out and bit_valid drop to 0 immediately; after release, IDLE with no residual bits.
REQ-032 data_valid=1 with data_in toggling during a frame -> emitted frame equals the word latched at accept.
